// File: rtl/ui_pkg.sv
// Shared UI encodings for the menu/mode control path: renderer state codes,
// menu size, button bit positions and the cursor wrap helper.
package ui_pkg;

  typedef enum logic [3:0] {
    UI_IDLE     = 4'd0,
    UI_MANUAL   = 4'd1,
    UI_SOLVER   = 4'd2,
    UI_GENERATE = 4'd3
  } ui_state_t;

  localparam int NUM_MENU_ITEMS = 3;

  localparam int BTN_UP     = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_BACK   = 3;
  localparam int NUM_BTNS   = 4;

  // Moves the cursor one entry up or down, wrapping at both ends of the menu.
  function automatic logic [1:0] cursor_step(input logic [1:0] cur, input logic dir_up);
    logic [1:0] last;
    last = 2'(NUM_MENU_ITEMS - 1);
    if (dir_up)
      return (cur == 2'd0) ? last : cur - 2'd1;
    return (cur == last) ? 2'd0 : cur + 2'd1;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// One raw button: 2-FF synchroniser, stability counter, and a one-cycle
// pulse on each accepted rising edge of the debounced level.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 650000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_reg;
  logic          level_reg;
  logic [CW-1:0] cnt_reg;
  logic          press_reg;

  // The counter only advances while the synchronised sample disagrees with
  // the accepted level, so any bounce back restarts the stability window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg  <= 2'b00;
      level_reg <= 1'b0;
      cnt_reg   <= '0;
      press_reg <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[0], raw};
      press_reg <= 1'b0;
      if (sync_reg[1] == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        level_reg <= sync_reg[1];
        cnt_reg   <= '0;
        press_reg <= sync_reg[1];
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  assign press = press_reg;

endmodule

// File: rtl/ui_mode_controller.sv
// Menu/mode controller: debounced buttons drive a pending UI state that is
// committed to the renderer only on frame_start_in. Optional UI_IDLE_TIMEOUT_EN.
module ui_mode_controller
  import ui_pkg::*;
#(
`ifdef UI_IDLE_TIMEOUT_EN
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd3900000000,
`endif
  parameter int DEBOUNCE_CYCLES = 650000
) (
  input  logic       clk_in,
  input  logic       reset_n_in,
  input  logic       btn_up_in,
  input  logic       btn_down_in,
  input  logic       btn_select_in,
  input  logic       btn_back_in,
  input  logic       frame_start_in,
  input  logic       mode_done_in,
  output logic [3:0] state_out,
  output logic [1:0] cursor_out,
  output logic       mode_start_out
);

  logic [NUM_BTNS-1:0] btn_raw;
  logic [NUM_BTNS-1:0] btn_press;

  assign btn_raw = {btn_back_in, btn_select_in, btn_down_in, btn_up_in};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
      button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debouncer (
        .clk  (clk_in),
        .rst_n(reset_n_in),
        .raw  (btn_raw[gi]),
        .press(btn_press[gi])
      );
    end
  endgenerate

  ui_state_t pend_state_reg, pend_state_next;
  logic [1:0] pend_cursor_reg, pend_cursor_next;
  ui_state_t state_out_reg;
  logic [1:0] cursor_out_reg;
  logic       mode_start_reg;
  logic       timeout_hit;

`ifdef UI_IDLE_TIMEOUT_EN
  logic [31:0] idle_cnt_reg;

  assign timeout_hit = (idle_cnt_reg == TIMEOUT_CYCLES);

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in)
      idle_cnt_reg <= 32'd0;
    else if ((|btn_press) || (pend_state_reg == UI_IDLE))
      idle_cnt_reg <= 32'd0;
    else if (!timeout_hit)
      idle_cnt_reg <= idle_cnt_reg + 32'd1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      pend_state_reg  <= UI_IDLE;
      pend_cursor_reg <= 2'd0;
    end else begin
      pend_state_reg  <= pend_state_next;
      pend_cursor_reg <= pend_cursor_next;
    end
  end

  // Only events meaningful in the current state compete; the if/else order
  // is the arbitration order when several arrive together.
  always_comb begin
    pend_state_next  = pend_state_reg;
    pend_cursor_next = pend_cursor_reg;
    if (pend_state_reg == UI_IDLE) begin
      if (btn_press[BTN_SELECT])
        pend_state_next = ui_state_t'({2'b00, pend_cursor_reg} + 4'd1);
      else if (btn_press[BTN_UP])
        pend_cursor_next = cursor_step(pend_cursor_reg, 1'b1);
      else if (btn_press[BTN_DOWN])
        pend_cursor_next = cursor_step(pend_cursor_reg, 1'b0);
    end else begin
      if (mode_done_in || btn_press[BTN_BACK] || timeout_hit)
        pend_state_next = UI_IDLE;
    end
  end

  // Visible outputs move only on the frame boundary so the renderer never
  // switches image mid-frame; mode_start marks a committed IDLE exit.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_out_reg  <= UI_IDLE;
      cursor_out_reg <= 2'd0;
      mode_start_reg <= 1'b0;
    end else if (frame_start_in) begin
      state_out_reg  <= pend_state_reg;
      cursor_out_reg <= pend_cursor_reg;
      mode_start_reg <= (state_out_reg == UI_IDLE) && (pend_state_reg != UI_IDLE);
    end else begin
      mode_start_reg <= 1'b0;
    end
  end

  assign state_out      = state_out_reg;
  assign cursor_out     = cursor_out_reg;
  assign mode_start_out = mode_start_reg;

endmodule

// File: tb/tb_ui_mode_controller.sv
// Directed bench for ui_mode_controller (DEBOUNCE_CYCLES=4, frame every 100
// cycles); expected frame commits are queued and checked as they appear.
module tb_ui_mode_controller;

  logic       clk_in = 1'b0;
  logic       reset_n_in;
  logic       btn_up_in, btn_down_in, btn_select_in, btn_back_in;
  logic       frame_start_in;
  logic       mode_done_in;
  logic [3:0] state_out;
  logic [1:0] cursor_out;
  logic       mode_start_out;

  typedef struct {
    logic [3:0] st;
    logic [1:0] cur;
    logic       ms;
    string      tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   fcnt = 0;
  int   n_commit = 0;
  bit   frames_on = 0;
  bit   armed = 0;
  logic frame_q = 1'b0;
  logic [3:0] vis_st = 4'd0;
  logic [1:0] vis_cur = 2'd0;

  ui_mode_controller #(.DEBOUNCE_CYCLES(4)) dut (
    .clk_in        (clk_in),
    .reset_n_in    (reset_n_in),
    .btn_up_in     (btn_up_in),
    .btn_down_in   (btn_down_in),
    .btn_select_in (btn_select_in),
    .btn_back_in   (btn_back_in),
    .frame_start_in(frame_start_in),
    .mode_done_in  (mode_done_in),
    .state_out     (state_out),
    .cursor_out    (cursor_out),
    .mode_start_out(mode_start_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Frame pulse generator
  initial begin
    frame_start_in = 1'b0;
    forever begin
      @(negedge clk_in);
      if (frames_on) begin
        fcnt++;
        frame_start_in = ((fcnt % 100) == 50);
      end
    end
  end

  initial forever begin
    @(posedge clk_in);
    frame_q = frame_start_in;
  end

  // Monitor: commits pop the scoreboard; other cycles must hold steady
  initial forever begin
    @(negedge clk_in);
    if (armed) begin
      if (frame_q === 1'b1) begin
        exp_t e;
        n_commit++;
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
        end else begin
          e.st = vis_st; e.cur = vis_cur; e.ms = 1'b0; e.tag = "hold";
        end
        $display("commit %0d [%s]: state=%0d cursor=%0d mode_start=%0d (want %0d/%0d/%0d)",
                 n_commit, e.tag, state_out, cursor_out, mode_start_out, e.st, e.cur, e.ms);
        check({e.tag, ".state"}, {4'd0, state_out}, {4'd0, e.st});
        check({e.tag, ".cursor"}, {6'd0, cursor_out}, {6'd0, e.cur});
        check({e.tag, ".mode_start"}, {7'd0, mode_start_out}, {7'd0, e.ms});
        vis_st = e.st;
        vis_cur = e.cur;
      end else begin
        check("steady.state", {4'd0, state_out}, {4'd0, vis_st});
        check("steady.cursor", {6'd0, cursor_out}, {6'd0, vis_cur});
        check("steady.mode_start", {7'd0, mode_start_out}, 8'd0);
      end
    end
  end

  task automatic expect_commit(input logic [3:0] st, input logic [1:0] cur, input logic ms,
                               input string tag);
    exp_t e;
    e.st = st; e.cur = cur; e.ms = ms; e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic wait_commit(input string tag);
    int k;
    for (k = 0; k < 400; k++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk_in);
    end
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s.timeout: observed pending=%0d required pending=0", tag, sb_q.size());
      sb_q.delete();
    end
  endtask

  // Hold the given buttons {back,select,down,up} 8 cycles, then release 8
  task automatic press(input logic [3:0] mask);
    {btn_back_in, btn_select_in, btn_down_in, btn_up_in} = mask;
    repeat (8) @(negedge clk_in);
    {btn_back_in, btn_select_in, btn_down_in, btn_up_in} = 4'b0000;
    repeat (8) @(negedge clk_in);
  endtask

  initial begin
    int k;
    reset_n_in = 1'b0;
    mode_done_in = 1'b0;
    {btn_back_in, btn_select_in, btn_up_in} = 3'b000;
    btn_down_in = 1'b1;

    // Reset with a button held: outputs at zero, no event until release
    repeat (10) @(negedge clk_in);
    check("reset.state", {4'd0, state_out}, 8'd0);
    check("reset.cursor", {6'd0, cursor_out}, 8'd0);
    check("reset.mode_start", {7'd0, mode_start_out}, 8'd0);
    reset_n_in = 1'b1;
    armed = 1;
    frames_on = 1;
    repeat (10) @(negedge clk_in);
    btn_down_in = 1'b0;
    repeat (8) @(negedge clk_in);
    expect_commit(4'd0, 2'd1, 1'b0, "reset_hold");
    wait_commit("reset_hold");

    // Bounce shorter than the debounce window, then a clean hold
    for (k = 0; k < 10; k++) begin
      btn_down_in = (k % 2 == 0);
      repeat (2) @(negedge clk_in);
    end
    press(4'b0010);
    expect_commit(4'd0, 2'd2, 1'b0, "bounce");
    wait_commit("bounce");

    press(4'b0010);
    expect_commit(4'd0, 2'd0, 1'b0, "wrap_down");
    wait_commit("wrap_down");
    press(4'b0001);
    expect_commit(4'd0, 2'd2, 1'b0, "wrap_up");
    wait_commit("wrap_up");
    press(4'b0010);
    press(4'b0010);
    expect_commit(4'd0, 2'd1, 1'b0, "down_twice");
    wait_commit("down_twice");
    press(4'b0010);
    expect_commit(4'd0, 2'd2, 1'b0, "to_generate_entry");
    wait_commit("to_generate_entry");

    press(4'b0100);
    expect_commit(4'd3, 2'd2, 1'b1, "select_generate");
    wait_commit("select_generate");
    expect_commit(4'd3, 2'd2, 1'b0, "mode_persists");
    wait_commit("mode_persists");
    press(4'b0010);
    press(4'b1000);
    expect_commit(4'd0, 2'd2, 1'b0, "back");
    wait_commit("back");

    // Select then mode_done inside one frame: never visible
    press(4'b0100);
    mode_done_in = 1'b1;
    @(negedge clk_in);
    mode_done_in = 1'b0;
    repeat (4) @(negedge clk_in);
    expect_commit(4'd0, 2'd2, 1'b0, "coalesce");
    wait_commit("coalesce");

    press(4'b1000);
    mode_done_in = 1'b1;
    @(negedge clk_in);
    mode_done_in = 1'b0;
    expect_commit(4'd0, 2'd2, 1'b0, "idle_back_ignored");
    wait_commit("idle_back_ignored");

    press(4'b0001);
    expect_commit(4'd0, 2'd1, 1'b0, "up_to_solver");
    wait_commit("up_to_solver");
    press(4'b0100);
    expect_commit(4'd2, 2'd1, 1'b1, "select_solver");
    wait_commit("select_solver");

    // Select event and mode_done in the same cycle while in SOLVER
    btn_select_in = 1'b1;
    repeat (6) @(negedge clk_in);
    mode_done_in = 1'b1;
    @(negedge clk_in);
    mode_done_in = 1'b0;
    @(negedge clk_in);
    btn_select_in = 1'b0;
    repeat (8) @(negedge clk_in);
    expect_commit(4'd0, 2'd1, 1'b0, "done_beats_select");
    wait_commit("done_beats_select");

    press(4'b0011);
    expect_commit(4'd0, 2'd0, 1'b0, "up_beats_down");
    wait_commit("up_beats_down");
    press(4'b0110);
    expect_commit(4'd1, 2'd0, 1'b1, "select_beats_down");
    wait_commit("select_beats_down");

    // mode_done coincident with frame_start lands one frame later
    expect_commit(4'd1, 2'd0, 1'b0, "same_cycle_excluded");
    for (k = 0; k < 200; k++) begin
      @(posedge clk_in);
      if ((fcnt % 100) == 49) break;
    end
    @(negedge clk_in);
    mode_done_in = 1'b1;
    @(negedge clk_in);
    mode_done_in = 1'b0;
    wait_commit("same_cycle_excluded");
    expect_commit(4'd0, 2'd0, 1'b0, "next_frame_idle");
    wait_commit("next_frame_idle");

    repeat (5) @(negedge clk_in);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
